ppu_vram_writer: RTL and testbench
==================================

Name: ppu_vram_writer

Overview:
- Write-side master for the PPU memory's write port (write_addr/write_data/write_en).
- Decodes CPU register writes to PPUCTRL ($2000), PPUADDR ($2006) and PPUDATA ($2007) into VRAM writes with NES-style address auto-increment.
- Contains a hardware clear engine that fills a VRAM region with a constant value after power-up.
- Sits between the CPU register bus and the PPU memory block, which performs its own mirroring and address decoding.

Parameters:
- CLEAR_BASE, 16'h2000, first PPU address written by the clear engine
- CLEAR_LEN, 16'h1000, number of bytes cleared; 0 means the clear engine finishes immediately with no writes
- CLEAR_VALUE, 8'h00, byte written by the clear engine
- ADDR_MASK, 16'h3FFF, PPU address space mask applied to every issued address

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- cpu_wr_en  in  1  single-cycle CPU register write strobe
- cpu_rd_en  in  1  single-cycle CPU register read strobe; only PPUSTATUS is acted on
- cpu_reg  in  3  register index (CPU address bits 2:0)
- cpu_wdata  in  8  CPU write data
- clear_start  in  1  pulse that starts the clear engine
- write_addr  out  16  PPU memory write address
- write_data  out  8  PPU memory write data
- write_en  out  1  PPU memory write strobe, one byte per cycle
- busy  out  1  high while the clear engine is running
- clear_done  out  1  one-cycle pulse when a clear completes
- vram_addr  out  16  current internal address v, masked

Behaviour:
- Reset (async, rst=0): write_addr=0, write_data=0, write_en=0, busy=0, clear_done=0, v=0, t=0, toggle w=0, inc32=0, FSM=IDLE.
- All outputs are registered.
- Register writes while the FSM is IDLE:
  - PPUCTRL (cpu_reg=0): inc32 <= cpu_wdata[2]. Accepted in any state.
  - PPUADDR (cpu_reg=6), w=0: t[13:8] <= cpu_wdata[5:0], t[15:14] <= 0, w <= 1.
  - PPUADDR, w=1: t[7:0] <= cpu_wdata; v <= {t[15:8], cpu_wdata}; w <= 0. The new v is visible on vram_addr the next cycle.
  - PPUDATA (cpu_reg=7): on the next cycle write_en=1, write_addr=v&ADDR_MASK, write_data=cpu_wdata (latency 1). In the same edge v <= (v + (inc32 ? 32 : 1)) & ADDR_MASK, so $3FFF+1 wraps to $0000.
  - Other cpu_reg values are ignored.
- Register read: cpu_rd_en with cpu_reg=2 clears w. If cpu_rd_en and a PPUADDR write occur in the same cycle, the clear applies first and the write is handled as a first (high-byte) write.
- write_en is deasserted in every cycle with no issued write.
- Clear FSM:
  - IDLE: clear_start=1 -> CLEAR; cnt <= 0; busy <= 1. Any PPUADDR/PPUDATA write in that same cycle is dropped.
  - CLEAR: each cycle write_en=1, write_addr=(CLEAR_BASE+cnt)&ADDR_MASK, write_data=CLEAR_VALUE; cnt increments. After the write with cnt=CLEAR_LEN-1 -> DONE.
  - DONE: busy <= 0; clear_done pulses for one cycle -> IDLE.
  - If CLEAR_LEN=0: IDLE -> DONE directly, with no writes.
- While busy: PPUADDR and PPUDATA writes are dropped silently (no state change, no write); clear_start is ignored; PPUSTATUS reads still clear w; PPUCTRL writes are still accepted.
- The clear engine does not modify v, t or w.
- Reset asserted mid-clear: immediate return to IDLE, all outputs to their reset values, no further writes.

Decomposition:
- Shared package ppu_reg_pkg holds:
  - register index constants: REG_PPUCTRL=3'd0, REG_PPUSTATUS=3'd2, REG_PPUADDR=3'd6, REG_PPUDATA=3'd7
  - FSM state encoding: IDLE, CLEAR, DONE
  - PPU_ADDR_MASK
- One sub-module, ppu_addr_latch, owns t, v, w and inc32: it handles PPUADDR high/low sequencing, PPUSTATUS toggle clear, and the post-PPUDATA increment. The top level owns the clear FSM and the output registers.

Test Plan:
- Write $20, $5A to PPUADDR, then $11, $22 to PPUDATA -> writes ($205A,$11), ($205B,$22), each one cycle after its strobe; vram_addr ends at $205C.
- PPUCTRL=$04, PPUADDR $23/$E0, PPUDATA $7F -> write ($23E0,$7F); vram_addr=$2400.
- PPUADDR $3F/$FF, PPUDATA $01 with inc32=0 -> write ($3FFF,$01); vram_addr wraps to $0000. PPUADDR high $FF -> t[13:8]=$3F.
- PPUADDR $21, then PPUSTATUS read, then PPUADDR $08, $00 -> v=$0800 (toggle was reset, so $08 is treated as the high byte).
- clear_start with CLEAR_LEN=16 -> 16 consecutive writes of $00 at $2000..$200F; busy high for 16 cycles; clear_done pulses once. A PPUDATA write mid-clear is dropped.
- rst asserted during a clear at cnt=5 -> write_en=0 immediately; after release busy=0 and no further writes occur.

Source files
------------

// File: rtl/ppu_vram_writer_pkg.sv
// Shared register indices, address mask and clear-engine state encoding for the PPU VRAM writer.
package ppu_reg_pkg;

  localparam logic [2:0] REG_PPUCTRL   = 3'd0;
  localparam logic [2:0] REG_PPUSTATUS = 3'd2;
  localparam logic [2:0] REG_PPUADDR   = 3'd6;
  localparam logic [2:0] REG_PPUDATA   = 3'd7;

  localparam logic [15:0] PPU_ADDR_MASK = 16'h3FFF;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } clr_state_e;

endpackage

// File: rtl/ppu_vram_writer_if.sv
// CPU register bus, clear control and PPU memory write port of the VRAM writer.
interface ppu_vram_writer_if;
  logic        cpu_wr_en;
  logic        cpu_rd_en;
  logic [2:0]  cpu_reg;
  logic [7:0]  cpu_wdata;
  logic        clear_start;
  logic [15:0] write_addr;
  logic [7:0]  write_data;
  logic        write_en;
  logic        busy;
  logic        clear_done;
  logic [15:0] vram_addr;

  // master: the CPU side driving register accesses; slave: the VRAM writer
  modport master (
    output cpu_wr_en, cpu_rd_en, cpu_reg, cpu_wdata, clear_start,
    input  write_addr, write_data, write_en, busy, clear_done, vram_addr
  );

  modport slave (
    input  cpu_wr_en, cpu_rd_en, cpu_reg, cpu_wdata, clear_start,
    output write_addr, write_data, write_en, busy, clear_done, vram_addr
  );
endinterface

// File: rtl/ppu_vram_writer_addr_latch.sv
// PPU address latch: temporary address t, current address v, write toggle w and increment mode.
module ppu_addr_latch
  import ppu_reg_pkg::*;
#(
  parameter logic [15:0] ADDR_MASK = PPU_ADDR_MASK
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_wr,
  input  logic        status_rd,
  input  logic        addr_wr,
  input  logic        data_wr,
  input  logic [7:0]  wdata,
  output logic [15:0] v,
  output logic        w,
  output logic        inc32
);

  logic [15:0] t;
  logic        w_eff;

  // a same-cycle status read resets the toggle before the PPUADDR write sees it
  assign w_eff = w & ~status_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t     <= '0;
      v     <= '0;
      w     <= 1'b0;
      inc32 <= 1'b0;
    end else begin
      if (ctrl_wr)
        inc32 <= wdata[2];

      if (addr_wr) begin
        if (!w_eff) begin
          t[15:8] <= {2'b00, wdata[5:0]};
          w       <= 1'b1;
        end else begin
          t[7:0] <= wdata;
          v      <= {t[15:8], wdata};
          w      <= 1'b0;
        end
      end else if (status_rd) begin
        w <= 1'b0;
      end

      if (data_wr)
        v <= (v + (inc32 ? 16'd32 : 16'd1)) & ADDR_MASK;
    end
  end

endmodule

// File: rtl/ppu_vram_writer.sv
// Write-side master for PPU memory: CPU PPUADDR/PPUDATA decoding plus a power-up VRAM clear engine.
module ppu_vram_writer
  import ppu_reg_pkg::*;
#(
  parameter logic [15:0] CLEAR_BASE  = 16'h2000,
  parameter logic [15:0] CLEAR_LEN   = 16'h1000,
  parameter logic [7:0]  CLEAR_VALUE = 8'h00,
  parameter logic [15:0] ADDR_MASK   = PPU_ADDR_MASK
) (
  input logic              clk,
  input logic              rst,
  ppu_vram_writer_if.slave bus
);

  clr_state_e  state, state_nxt;
  logic [15:0] cnt;
  logic [15:0] v;
  logic        w;
  logic        inc32;
  logic        accept;
  logic        ctrl_wr, status_rd, addr_wr, data_wr;

  // address/data writes only land in IDLE and never in the cycle a clear starts
  assign accept    = (state == IDLE) && !bus.clear_start;
  assign ctrl_wr   = bus.cpu_wr_en && (bus.cpu_reg == REG_PPUCTRL);
  assign status_rd = bus.cpu_rd_en && (bus.cpu_reg == REG_PPUSTATUS);
  assign addr_wr   = bus.cpu_wr_en && (bus.cpu_reg == REG_PPUADDR) && accept;
  assign data_wr   = bus.cpu_wr_en && (bus.cpu_reg == REG_PPUDATA) && accept;

  ppu_addr_latch #(
    .ADDR_MASK(ADDR_MASK)
  ) u_latch (
    .clk      (clk),
    .rst      (rst),
    .ctrl_wr  (ctrl_wr),
    .status_rd(status_rd),
    .addr_wr  (addr_wr),
    .data_wr  (data_wr),
    .wdata    (bus.cpu_wdata),
    .v        (v),
    .w        (w),
    .inc32    (inc32)
  );

  assign bus.vram_addr = v & ADDR_MASK;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.clear_start) state_nxt = (CLEAR_LEN == 16'd0) ? DONE : CLEAR;
      CLEAR:   if (cnt == CLEAR_LEN - 16'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy tracks the cycles spent in CLEAR, so it is high exactly CLEAR_LEN cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.write_addr <= '0;
      bus.write_data <= '0;
      bus.write_en   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.clear_done <= 1'b0;
      cnt            <= '0;
    end else begin
      bus.write_en   <= 1'b0;
      bus.clear_done <= 1'b0;
      bus.busy       <= (state_nxt == CLEAR);
      case (state)
        IDLE: begin
          if (bus.clear_start) begin
            cnt <= '0;
          end else if (data_wr) begin
            bus.write_en   <= 1'b1;
            bus.write_addr <= v & ADDR_MASK;
            bus.write_data <= bus.cpu_wdata;
          end
        end
        CLEAR: begin
          bus.write_en   <= 1'b1;
          bus.write_addr <= (CLEAR_BASE + cnt) & ADDR_MASK;
          bus.write_data <= CLEAR_VALUE;
          cnt            <= cnt + 16'd1;
        end
        DONE:    bus.clear_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_vram_writer.sv
// Directed self-checking bench for ppu_vram_writer with a 16-byte clear region.
module tb_ppu_vram_writer;
  import ppu_reg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned errors = 0;
  int unsigned checks = 0;

  ppu_vram_writer_if bus();

  ppu_vram_writer #(
    .CLEAR_BASE (16'h2000),
    .CLEAR_LEN  (16'd16),
    .CLEAR_VALUE(8'h00),
    .ADDR_MASK  (16'h3FFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive a one-cycle register write starting at a negedge; returns at the following negedge
  task automatic cpu_write(input logic [2:0] r, input logic [7:0] d);
    bus.cpu_wr_en = 1'b1;
    bus.cpu_reg   = r;
    bus.cpu_wdata = d;
    @(negedge clk);
    bus.cpu_wr_en = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] r);
    bus.cpu_rd_en = 1'b1;
    bus.cpu_reg   = r;
    @(negedge clk);
    bus.cpu_rd_en = 1'b0;
  endtask

  initial begin
    int unsigned nw, nb, nd;
    bit found;

    bus.cpu_wr_en   = 1'b0;
    bus.cpu_rd_en   = 1'b0;
    bus.cpu_reg     = '0;
    bus.cpu_wdata   = '0;
    bus.clear_start = 1'b0;

    #2;
    check_eq("rst_write_en", {31'd0, bus.write_en}, 32'd0);
    check_eq("rst_write_addr", {16'd0, bus.write_addr}, 32'd0);
    check_eq("rst_write_data", {24'd0, bus.write_data}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_clear_done", {31'd0, bus.clear_done}, 32'd0);
    check_eq("rst_vram_addr", {16'd0, bus.vram_addr}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // sequential PPUDATA writes with +1 increment
    cpu_write(REG_PPUADDR, 8'h20);
    cpu_write(REG_PPUADDR, 8'h5A);
    check_eq("t1_vram_after_addr", {16'd0, bus.vram_addr}, 32'h205A);
    check_eq("t1_no_write_idle", {31'd0, bus.write_en}, 32'd0);
    cpu_write(REG_PPUDATA, 8'h11);
    check_eq("t1_we0", {31'd0, bus.write_en}, 32'd1);
    check_eq("t1_addr0", {16'd0, bus.write_addr}, 32'h205A);
    check_eq("t1_data0", {24'd0, bus.write_data}, 32'h11);
    cpu_write(REG_PPUDATA, 8'h22);
    check_eq("t1_we1", {31'd0, bus.write_en}, 32'd1);
    check_eq("t1_addr1", {16'd0, bus.write_addr}, 32'h205B);
    check_eq("t1_data1", {24'd0, bus.write_data}, 32'h22);
    check_eq("t1_vram_end", {16'd0, bus.vram_addr}, 32'h205C);
    @(negedge clk);
    check_eq("t1_we_deassert", {31'd0, bus.write_en}, 32'd0);

    // +32 increment mode
    cpu_write(REG_PPUCTRL, 8'h04);
    cpu_write(REG_PPUADDR, 8'h23);
    cpu_write(REG_PPUADDR, 8'hE0);
    cpu_write(REG_PPUDATA, 8'h7F);
    check_eq("t2_we", {31'd0, bus.write_en}, 32'd1);
    check_eq("t2_addr", {16'd0, bus.write_addr}, 32'h23E0);
    check_eq("t2_data", {24'd0, bus.write_data}, 32'h7F);
    check_eq("t2_vram", {16'd0, bus.vram_addr}, 32'h2400);
    cpu_write(REG_PPUCTRL, 8'h00);

    // wrap at top of PPU space and high-byte masking
    cpu_write(REG_PPUADDR, 8'h3F);
    cpu_write(REG_PPUADDR, 8'hFF);
    cpu_write(REG_PPUDATA, 8'h01);
    check_eq("t3_addr", {16'd0, bus.write_addr}, 32'h3FFF);
    check_eq("t3_data", {24'd0, bus.write_data}, 32'h01);
    check_eq("t3_vram_wrap", {16'd0, bus.vram_addr}, 32'h0000);
    cpu_write(REG_PPUADDR, 8'hFF);
    cpu_write(REG_PPUADDR, 8'h00);
    check_eq("t3_high_mask", {16'd0, bus.vram_addr}, 32'h3F00);

    // PPUSTATUS read resets the toggle
    cpu_write(REG_PPUADDR, 8'h21);
    cpu_read(REG_PPUSTATUS);
    cpu_write(REG_PPUADDR, 8'h08);
    cpu_write(REG_PPUADDR, 8'h00);
    check_eq("t4_vram_toggle", {16'd0, bus.vram_addr}, 32'h0800);

    // full clear with a PPUDATA write attempted mid-clear
    bus.clear_start = 1'b1;
    @(negedge clk);
    bus.clear_start = 1'b0;
    nw = 0; nb = 0; nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.write_en) begin
        check_eq($sformatf("t5_addr%0d", nw), {16'd0, bus.write_addr}, 32'h2000 + nw);
        check_eq($sformatf("t5_data%0d", nw), {24'd0, bus.write_data}, 32'h00);
        nw++;
      end
      if (bus.busy) nb++;
      if (bus.clear_done) nd++;
      if (i == 5) begin
        bus.cpu_wr_en = 1'b1;
        bus.cpu_reg   = REG_PPUDATA;
        bus.cpu_wdata = 8'hAA;
      end else begin
        bus.cpu_wr_en = 1'b0;
      end
      @(negedge clk);
    end
    check_eq("t5_write_count", nw, 32'd16);
    check_eq("t5_busy_cycles", nb, 32'd16);
    check_eq("t5_done_pulses", nd, 32'd1);
    check_eq("t5_vram_untouched", {16'd0, bus.vram_addr}, 32'h0800);

    // reset in the middle of a clear
    bus.clear_start = 1'b1;
    @(negedge clk);
    bus.clear_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (bus.write_en && bus.write_addr == 16'h2005) found = 1'b1;
      else @(negedge clk);
    end
    check_eq("t6_reached_cnt5", {31'd0, found}, 32'd1);
    rst = 1'b0;
    #1;
    check_eq("t6_we_in_reset", {31'd0, bus.write_en}, 32'd0);
    check_eq("t6_busy_in_reset", {31'd0, bus.busy}, 32'd0);
    check_eq("t6_addr_in_reset", {16'd0, bus.write_addr}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nw = 0; nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.write_en) nw++;
      if (bus.busy) nb++;
    end
    check_eq("t6_writes_after", nw, 32'd0);
    check_eq("t6_busy_after", nb, 32'd0);
    check_eq("t6_vram_reset", {16'd0, bus.vram_addr}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
